// File: rtl/traffic_pkg.sv
// Shared state encoding, width helper and default timing for traffic_phase_ctrl.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2,
    PED    = 2'd3
  } tl_state_e;

  localparam int DEF_NUM_DIR     = 4;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_T_MIN_GREEN = 10;
  localparam int DEF_T_MAX_GREEN = 40;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALLRED    = 1;
  localparam int DEF_T_PED       = 8;

  function automatic int dir_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Sensor-side inputs and lamp/status outputs of traffic_phase_ctrl.
// ped_req/walk exist only when TRAFFIC_PED_EN is defined.
interface traffic_phase_ctrl_if
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = DEF_NUM_DIR,
  parameter int CNT_W   = DEF_CNT_W
) ();
  localparam int PW = dir_w(NUM_DIR);

  logic               tick;
  logic [NUM_DIR-1:0] car;
  logic [NUM_DIR-1:0] full;
  logic [PW-1:0]      phase;
  logic [NUM_DIR-1:0] green;
  logic [NUM_DIR-1:0] yellow;
  logic               allred;
  logic               mode_reg;
  logic               delay_reg;
  logic [CNT_W-1:0]   timer;
`ifdef TRAFFIC_PED_EN
  logic               ped_req;
  logic               walk;
`endif

  modport master (
    output tick, car, full,
    input  phase, green, yellow, allred, mode_reg, delay_reg, timer
`ifdef TRAFFIC_PED_EN
    , output ped_req
    , input  walk
`endif
  );

  modport slave (
    input  tick, car, full,
    output phase, green, yellow, allred, mode_reg, delay_reg, timer
`ifdef TRAFFIC_PED_EN
    , input  ped_req
    , output walk
`endif
  );

endinterface

// File: rtl/traffic_phase_ctrl_rr_next_dir.sv
// Round-robin pick of the first requesting direction after cur_i (wrapping back
// to cur_i itself); with no request at all it simply advances by one.
module rr_next_dir
  import traffic_pkg::*;
#(
  parameter int  NUM_DIR = DEF_NUM_DIR,
  localparam int PW      = dir_w(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] req_i,
  input  logic [PW-1:0]      cur_i,
  output logic [PW-1:0]      nxt_o,
  output logic               any_o
);

  function automatic logic [PW-1:0] step(input logic [PW-1:0] cur, input int k);
    logic [PW:0] s;
    s = {1'b0, cur} + (PW+1)'(k);
    if (s >= (PW+1)'(NUM_DIR)) s = s - (PW+1)'(NUM_DIR);
    return s[PW-1:0];
  endfunction

  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    nxt_o = step(cur_i, 1);
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      cand = step(cur_i, k);
      if (!found && req_i[cand]) begin
        nxt_o = cand;
        found = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-direction demand-actuated traffic phase controller with green extension.
// Optional pedestrian walk phase enabled by TRAFFIC_PED_EN.
//   state  | meaning
//   GREEN  | phase direction green, extendable up to T_MAX_GREEN
//   YELLOW | phase direction yellow for T_YELLOW ticks
//   ALLRED | clearance, next direction chosen on exit
//   PED    | all red with walk lamp (TRAFFIC_PED_EN only)
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR     = DEF_NUM_DIR,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
  parameter int T_MAX_GREEN = DEF_T_MAX_GREEN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED
`ifdef TRAFFIC_PED_EN
  , parameter int T_PED     = DEF_T_PED
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_ctrl_if.slave  bus
);

  localparam int PW = dir_w(NUM_DIR);
  localparam logic [CNT_W:0] MIN_G = (CNT_W+1)'(T_MIN_GREEN);
  localparam logic [CNT_W:0] MAX_G = (CNT_W+1)'(T_MAX_GREEN);
  localparam logic [CNT_W:0] YEL_T = (CNT_W+1)'(T_YELLOW);
  localparam logic [CNT_W:0] AR_T  = (CNT_W+1)'(T_ALLRED);
`ifdef TRAFFIC_PED_EN
  localparam logic [CNT_W:0] PED_T = (CNT_W+1)'(T_PED);
`endif

  if (NUM_DIR < 2) begin : g_chk_dir
    $error("traffic_phase_ctrl: NUM_DIR must be at least 2");
  end
  if (T_MIN_GREEN < 1 || T_MAX_GREEN < T_MIN_GREEN || T_MAX_GREEN >= (1 << CNT_W)) begin : g_chk_green
    $error("traffic_phase_ctrl: green timing out of range");
  end
  if (T_YELLOW < 1 || T_ALLRED < 1 || T_YELLOW >= (1 << CNT_W) || T_ALLRED >= (1 << CNT_W)) begin : g_chk_clear
    $error("traffic_phase_ctrl: yellow/all-red timing out of range");
  end
`ifdef TRAFFIC_PED_EN
  if (T_PED < 1 || T_PED >= (1 << CNT_W)) begin : g_chk_ped
    $error("traffic_phase_ctrl: T_PED out of range");
  end
`endif

  tl_state_e          state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d, rr_next;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W:0]     timer_inc;
  logic [NUM_DIR-1:0] cur_oh;
  logic               any_req, ext;
  logic               mode_q, delay_q, delay_d;
`ifdef TRAFFIC_PED_EN
  logic               ped_flag_q, ped_flag_d;
`endif

  rr_next_dir #(.NUM_DIR(NUM_DIR)) u_rr (
    .req_i (bus.car),
    .cur_i (phase_q),
    .nxt_o (rr_next),
    .any_o (any_req)
  );

  // Extend while the served queue is full, or it is the only direction waiting.
  assign cur_oh    = NUM_DIR'(1) << phase_q;
  assign ext       = bus.full[phase_q] | (bus.car[phase_q] & ~|(bus.car & ~cur_oh));
  assign timer_inc = {1'b0, timer_q} + (CNT_W+1)'(1);
  assign delay_d   = ext & (state_q == GREEN) & (timer_inc >= MIN_G);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    timer_d = timer_q;
`ifdef TRAFFIC_PED_EN
    ped_flag_d = ped_flag_q | bus.ped_req;
`endif
    if (bus.tick) begin
      timer_d = timer_inc[CNT_W-1:0];
      case (state_q)
        GREEN: begin
          if (timer_inc >= MAX_G || (timer_inc >= MIN_G && !ext)) state_d = YELLOW;
        end
        YELLOW: begin
          if (timer_inc >= YEL_T) state_d = ALLRED;
        end
        ALLRED: begin
          if (timer_inc >= AR_T) begin
`ifdef TRAFFIC_PED_EN
            if (ped_flag_q) begin
              state_d    = PED;
              ped_flag_d = 1'b0;
            end else begin
              state_d = GREEN;
              phase_d = rr_next;
            end
`else
            state_d = GREEN;
            phase_d = rr_next;
`endif
          end
        end
`ifdef TRAFFIC_PED_EN
        PED: begin
          if (timer_inc >= PED_T) begin
            state_d = GREEN;
            phase_d = rr_next;
          end
        end
`endif
        default: state_d = ALLRED;
      endcase
      if (state_d != state_q) timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ALLRED;
      phase_q <= PW'(NUM_DIR - 1);
      timer_q <= '0;
      mode_q  <= 1'b1;
      delay_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
      mode_q  <= ~any_req;
      delay_q <= delay_d;
    end
  end

`ifdef TRAFFIC_PED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ped_flag_q <= 1'b0;
    else     ped_flag_q <= ped_flag_d;
  end

  assign bus.walk   = (state_q == PED);
  assign bus.allred = (state_q == ALLRED) | (state_q == PED);
`else
  assign bus.allred = (state_q == ALLRED);
`endif

  assign bus.phase     = phase_q;
  assign bus.green     = (state_q == GREEN)  ? cur_oh : '0;
  assign bus.yellow    = (state_q == YELLOW) ? cur_oh : '0;
  assign bus.mode_reg  = mode_q;
  assign bus.delay_reg = delay_q;
  assign bus.timer     = timer_q;

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised N-direction traffic-light phase controller; successor to the fixed 2-bit-state mode/delay decoder.
- Owns the full phase FSM: green, yellow and all-red timing with per-second tick counting.
- Demand-actuated round-robin phase selection and green extension on full queues.
- Drives lamp outputs plus registered mode/delay status; sits between the vehicle sensor front-end and the lamp drivers.

Parameters:
- NUM_DIR, 4, number of approach directions (>=2).
- CNT_W, 8, phase timer width in ticks.
- T_MIN_GREEN, 10, minimum green ticks (>=1).
- T_MAX_GREEN, 40, maximum green ticks (>=T_MIN_GREEN, <2^CNT_W).
- T_YELLOW, 3, yellow ticks (>=1).
- T_ALLRED, 1, all-red clearance ticks (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  one-cycle timebase strobe; all timers advance only when tick=1.
- car  in  NUM_DIR  vehicle present per direction.
- full  in  NUM_DIR  queue full per direction.
- phase  out  $clog2(NUM_DIR)  direction currently served.
- green  out  NUM_DIR  one-hot green lamp; zero outside GREEN.
- yellow  out  NUM_DIR  one-hot yellow lamp; zero outside YELLOW.
- allred  out  1  high in ALLRED.
- mode_reg  out  1  1 = fixed-time rotation (no demand), 0 = actuated.
- delay_reg  out  1  1 = current green is being extended.
- timer  out  CNT_W  ticks elapsed in current state.

Behaviour:
- Reset (async, active-high):
  - State ALLRED, phase=NUM_DIR-1, timer=0.
  - green=0, yellow=0, allred=1, mode_reg=1, delay_reg=0.
- FSM states: GREEN, YELLOW, ALLRED. All state, timer and phase changes occur only on clk edges with tick=1.
- Timer:
  - On tick, if the state does not change, timer+1; on every state change, timer=0.
  - Timer never wraps: parameter limits keep it below 2^CNT_W.
- Combinational mode = ~|car.
- Combinational ext = full[phase] | (car[phase] & ~|(car & ~onehot(phase))).
- GREEN exit to YELLOW on tick when either:
  - timer+1 >= T_MAX_GREEN, or
  - timer+1 >= T_MIN_GREEN and ext=0.
- YELLOW exit to ALLRED on tick when timer+1 >= T_YELLOW.
- ALLRED exit to GREEN on tick when timer+1 >= T_ALLRED. phase loads the next direction:
  - First direction with car set, searching from phase+1 with wrap modulo NUM_DIR.
  - If car=0, phase+1 modulo NUM_DIR.
  - If only the current phase requests, it is reselected.
- Lamps decoded from registered state/phase; change the same cycle state changes.
- mode_reg and delay_reg:
  - Sampled every clk edge regardless of tick; one-cycle latency from inputs.
  - delay_reg = ext & (state==GREEN) & (timer+1 >= T_MIN_GREEN).
- Boundary conditions:
  - Inputs change without tick: only mode_reg/delay_reg react.
  - full and car both set on the same direction: full dominates, extension holds until T_MAX_GREEN.
  - rst mid-phase: immediate return to reset values; tick during rst ignored.
  - Illegal parameters: elaboration-time $error.

Optional Feature:
- Macro TRAFFIC_PED_EN.
- With it:
  - Adds input ped_req (1) and output walk (1), plus parameter T_PED, default 8.
  - ped_req is latched in a sticky flag.
  - On ALLRED exit with flag set, enter PED state: all lamps red, allred=1, walk=1, for T_PED ticks. Then go to GREEN with normal phase selection; the flag clears on PED entry.
  - Reset clears the flag; walk=0.
- Without it: ports, parameter and PED state are absent; FSM is the three-state version.

Decomposition:
- Package traffic_pkg:
  - State enum (GREEN, YELLOW, ALLRED, PED).
  - Function dir_w(n) = $clog2(n).
  - Default timing constants.
- Sub-module rr_next_dir:
  - Combinational round-robin search.
  - Inputs: req[NUM_DIR], cur phase.
  - Outputs: next phase, any_req.

Test Plan:
- Reset, car=0, tick every cycle:
  - Phase sequence 0,1,2,3,0.
  - green held exactly 10 ticks, yellow 3, allred 1.
  - mode_reg=1, delay_reg=0 throughout.
- car=0001 only, full=0:
  - Phase 0 green extends to 40 ticks, delay_reg=1 from tick 10.
  - Phase 0 is reselected after all-red.
- car=0101, full=0001:
  - Phase 0 green lasts 40 ticks.
  - Next phase 2; phases 1 and 3 skipped.
- car=1111, full=0, tick every 5th cycle:
  - Green spans 50 clk cycles.
  - mode_reg falls one cycle after car rises.
- Assert rst at green timer=6:
  - Outputs return to reset values asynchronously, before the next clk edge.
  - First green after release goes to phase 0.
- TRAFFIC_PED_EN build, pulse ped_req during green of phase 1:
  - After yellow and all-red: walk=1 for 8 ticks, then green of the next phase.
